// File: rtl/cond_unit.sv
// Condition unit: holds the NZCV flags, tests each instruction's condition
// against them, and registers the gated write strobes for write-back.
module cond_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter bit         NV_EXEC  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       valid_in,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic [3:0] flags_q,
  output logic       cond_ex_q,
  output logic       pcs_q,
  output logic       reg_w_q,
  output logic       mem_w_q,
  output logic       valid_q
);

  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_pass;
  logic       cond_ex;
  logic [3:0] flags_d;
  logic       cond_ex_d, pcs_d, reg_w_d, mem_w_d, valid_d;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Uses only the stored flags, never this instruction's own alu_flags.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = NV_EXEC;
    endcase
  end

  assign cond_ex = valid_in && cond_pass;

  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    pcs_d     = pcs_q;
    reg_w_d   = reg_w_q;
    mem_w_d   = mem_w_q;
    valid_d   = valid_q;
    if (en) begin
      valid_d   = valid_in;
      cond_ex_d = cond_ex;
      pcs_d     = pcs && cond_ex;
      mem_w_d   = mem_w && cond_ex;
      reg_w_d   = reg_w && cond_ex && !no_write;
      // N,Z and C,V halves update independently.
      if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= FLAG_RST;
      cond_ex_q <= 1'b0;
      pcs_q     <= 1'b0;
      reg_w_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
      pcs_q     <= pcs_d;
      reg_w_q   <= reg_w_d;
      mem_w_q   <= mem_w_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: two instances (NV_EXEC=0 and 1) driven in lockstep,
// compared each cycle against a behavioural model of the condition rules.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset, en, valid_in, pcs, reg_w, mem_w, no_write;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_w;

  localparam logic [3:0] RST_VAL [2] = '{4'b0000, 4'b1010};
  localparam bit         NV_VAL  [2] = '{1'b0, 1'b1};

  logic [3:0] o_flags [2];
  logic       o_cond_ex [2];
  logic       o_pcs [2];
  logic       o_reg_w [2];
  logic       o_mem_w [2];
  logic       o_valid [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      cond_unit #(
        .FLAG_RST (RST_VAL[gi]),
        .NV_EXEC  (NV_VAL[gi])
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .valid_in  (valid_in),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .flags_q   (o_flags[gi]),
        .cond_ex_q (o_cond_ex[gi]),
        .pcs_q     (o_pcs[gi]),
        .reg_w_q   (o_reg_w[gi]),
        .mem_w_q   (o_mem_w[gi]),
        .valid_q   (o_valid[gi])
      );
    end
  endgenerate

  // Reference model state
  logic [3:0] m_flags [2];
  logic       m_cond_ex [2], m_pcs [2], m_reg_w [2], m_mem_w [2], m_valid [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Conditions come in complementary pairs: cond[3:1] selects a predicate,
  // cond[0] inverts it; 1110 is always, 1111 follows NV_EXEC.
  function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f, input bit nv);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return nv;
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy & ~z;
      5: base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic step(input string tag, input logic r, input logic e, input logic vi,
                      input logic [3:0] cnd, input logic [3:0] af, input logic [1:0] fw,
                      input logic p, input logic rw, input logic mw, input logic nw);
    logic [3:0] nf [2];
    logic       nce [2], np [2], nr [2], nm [2], nv [2];
    reset = r; en = e; valid_in = vi; cond = cnd; alu_flags = af; flag_w = fw;
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    for (int k = 0; k < 2; k++) begin
      nf[k] = m_flags[k]; nce[k] = m_cond_ex[k]; np[k] = m_pcs[k];
      nr[k] = m_reg_w[k]; nm[k] = m_mem_w[k]; nv[k] = m_valid[k];
      if (r) begin
        nf[k] = RST_VAL[k]; nce[k] = 0; np[k] = 0; nr[k] = 0; nm[k] = 0; nv[k] = 0;
      end else if (e) begin
        logic ex;
        ex = vi && ref_eval(cnd, m_flags[k], NV_VAL[k]);
        nv[k] = vi; nce[k] = ex; np[k] = p & ex; nm[k] = mw & ex; nr[k] = rw & ex & ~nw;
        if (ex && fw[1]) nf[k][3:2] = af[3:2];
        if (ex && fw[0]) nf[k][1:0] = af[1:0];
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_flags[k] = nf[k]; m_cond_ex[k] = nce[k]; m_pcs[k] = np[k];
      m_reg_w[k] = nr[k]; m_mem_w[k] = nm[k]; m_valid[k] = nv[k];
      chk($sformatf("%s_dut%0d{flags,cx,pcs,rw,mw,v}", tag, k),
          {23'd0, o_flags[k], o_cond_ex[k], o_pcs[k], o_reg_w[k], o_mem_w[k], o_valid[k]},
          {23'd0, m_flags[k], m_cond_ex[k], m_pcs[k], m_reg_w[k], m_mem_w[k], m_valid[k]});
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_flags[k] = 'x; m_cond_ex[k] = 'x; m_pcs[k] = 'x;
      m_reg_w[k] = 'x; m_mem_w[k] = 'x; m_valid[k] = 'x;
    end
    #2;
    step("rst", 1, 1, 1, 4'he, 4'hf, 2'b11, 1, 1, 1, 0);
    chk("rst_flags_dut1", {28'd0, o_flags[1]}, 32'hA);

    // 1: AL with flag write
    step("t1", 0, 1, 1, 4'he, 4'b0100, 2'b11, 0, 1, 0, 0);
    chk("t1_reg_w_q", {31'd0, o_reg_w[0]}, 32'd1);
    chk("t1_flags", {28'd0, o_flags[0]}, 32'h4);
    // 2: EQ passes, NE fails
    step("t2eq", 0, 1, 1, 4'h0, 4'hf, 2'b00, 0, 0, 1, 0);
    chk("t2_eq_mem_w_q", {31'd0, o_mem_w[0]}, 32'd1);
    step("t2ne", 0, 1, 1, 4'h1, 4'hf, 2'b11, 0, 0, 1, 0);
    chk("t2_ne_mem_w_q", {31'd0, o_mem_w[0]}, 32'd0);
    chk("t2_ne_flags", {28'd0, o_flags[0]}, 32'h4);
    // 3: compare then LT/GE
    step("t3cmp", 0, 1, 1, 4'he, 4'b1000, 2'b11, 0, 1, 0, 1);
    chk("t3_cmp_reg_w_q", {31'd0, o_reg_w[0]}, 32'd0);
    step("t3lt", 0, 1, 1, 4'hb, 4'h0, 2'b00, 0, 0, 0, 0);
    chk("t3_lt_cond_ex", {31'd0, o_cond_ex[0]}, 32'd1);
    step("t3ge", 0, 1, 1, 4'ha, 4'h0, 2'b00, 0, 0, 0, 0);
    chk("t3_ge_cond_ex", {31'd0, o_cond_ex[0]}, 32'd0);
    // 4: split flag halves
    step("t4set", 0, 1, 1, 4'he, 4'b0001, 2'b11, 0, 0, 0, 0);
    step("t4nz", 0, 1, 1, 4'he, 4'b0011, 2'b10, 0, 0, 0, 0);
    chk("t4_nz_flags", {28'd0, o_flags[0]}, 32'h1);
    step("t4cv", 0, 1, 1, 4'he, 4'b0011, 2'b01, 0, 0, 0, 0);
    chk("t4_cv_flags", {28'd0, o_flags[0]}, 32'h3);
    // 5: stall, then reset during stall
    step("t5arm", 0, 1, 1, 4'he, 4'b1111, 2'b11, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("t5stall", 0, 0, 1, 4'he, 4'b0000, 2'b11, 1, 1, 1, 0);
    chk("t5_stall_flags", {28'd0, o_flags[0]}, 32'hf);
    step("t5rst", 1, 0, 1, 4'he, 4'b0101, 2'b11, 1, 1, 1, 0);
    chk("t5_rst_flags", {28'd0, o_flags[0]}, 32'h0);
    chk("t5_rst_pcs", {31'd0, o_pcs[0]}, 32'd0);
    // 6: sweep every flag value against every condition
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        step("sw_set", 0, 1, 1, 4'he, 4'(f), 2'b11, 0, 0, 0, 0);
        step($sformatf("sw_f%0d_c%0d", f, c), 0, 1, 1, 4'(c), 4'(f ^ 4'h9), 2'b00, 1, 1, 1, 0);
      end
    end
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 4) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
